deg_clk_ctrl: RTL
=================

// Module: deg_clk_ctrl
// PURPOSE
//  Run-time controller for the slow-clock divider: generates d_clk from clk with a
//  programmable half-period and sequences start/stop and ratio changes so that d_clk
//  never shows a shortened (runt) phase. Sits between the top-level control logic
//  and every block clocked or enabled by the divided clock.
// PARAMETERS
//  CNT_W     27      width of half-period counter and cfg_half
//  DEF_HALF  500000  half-period (clk cycles) loaded at reset
// PORTS
//  clk        in   1      system clock
//  rst_n      in   1      asynchronous active-low reset
//  start      in   1      level sampled per cycle; starts divider from IDLE
//  stop       in   1      level sampled per cycle; requests glitch-free stop
//  cfg_valid  in   1      new half-period offered
//  cfg_half   in   CNT_W  requested half-period (clk cycles)
//  cfg_ready  out  1      controller can accept cfg (transfer = valid & ready)
//  d_clk      out  1      divided clock, period 2*half
//  tick       out  1      one-cycle pulse on the cycle d_clk toggles
//  running    out  1      high in RUN, PEND, DRAIN
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE, cnt=0, half=DEF_HALF, shadow=DEF_HALF,
//    d_clk=0, tick=0, running=0, cfg_ready=1. All outputs registered.
//  - Counter: in RUN/PEND/DRAIN cnt increments each clk; when cnt==half-1:
//    d_clk<=~d_clk, tick<=1, cnt<=0 (the "boundary"). Toggle every half cycles.
//  - cfg_half==0 is clamped to 1 on acceptance (d_clk toggles every clk).
//  - FSM states: IDLE, RUN, PEND, DRAIN.
//    IDLE : cfg transfer loads half directly. start & !stop -> RUN, cnt=0,
//           first toggle (0->1) after half cycles. start & stop -> stay IDLE.
//    RUN  : cfg transfer -> shadow, go PEND. stop (checked after cfg) -> DRAIN
//           (cfg accepted the same cycle still goes to shadow, pending flag set).
//           start ignored.
//    PEND : cfg_ready=0. At next boundary half<=shadow, cnt<=0, -> RUN; the
//           phase in progress completes with old half. stop -> DRAIN, pending kept.
//    DRAIN: cfg_ready=0. If d_clk==0 on entry cycle -> IDLE next cycle, no toggle.
//           Else wait for boundary where d_clk falls 1->0, then IDLE, cnt=0.
//           Pending cfg (if any) loads into half on DRAIN exit.
//  - cfg_ready = 1 in IDLE and RUN, 0 in PEND and DRAIN.
//  - d_clk always 0 in IDLE; a stopped divider never leaves d_clk high.
//  - Boundary and stop same cycle in RUN with d_clk=1: toggle to 0 happens, DRAIN
//    sees d_clk==0 next cycle -> IDLE (no extra high phase).
//  - Reset mid-operation: immediate return to reset values; pending cfg lost.
// CONFIGURATION
//  - DEG_CLK_TOGGLE_CNT_EN defined: adds output toggle_cnt [15:0], reset 0,
//    +1 on every tick, wraps 16'hFFFF->0, held (not cleared) in IDLE.
//  - Not defined: port and counter absent; all other behaviour identical.
// TESTING (bench uses DEF_HALF=4, CNT_W=8)
//  1 Reset release, start=1 one cycle -> d_clk rises 4 clks after RUN entry,
//    falls 4 later; tick high 1 cycle at each edge; running=1.
//  2 In IDLE cfg_half=2 valid -> accepted same cycle; start -> toggles every 2 clks.
//  3 RUN with half=4, cfg_half=6 at cnt=1 -> cfg_ready low, current phase still 4,
//    following phases 6; cfg_ready returns 1 after boundary.
//  4 stop while d_clk=1 at cnt=0 -> d_clk falls after 4 clks, then IDLE, running=0,
//    d_clk stays 0; stop while d_clk=0 -> IDLE next cycle, no edge.
//  5 cfg_half=0 in IDLE, start -> d_clk toggles every clk, tick stuck high.
//  6 rst_n low mid-PEND -> outputs at reset values asynchronously; after release
//    start gives half=4 (shadow discarded). With DEG_CLK_TOGGLE_CNT_EN: count 3
//    ticks -> toggle_cnt=3, preset-by-run 65536 ticks -> wraps to 0.

Source files
------------

// File: rtl/deg_clk_ctrl.sv
// Run-time controller for the slow-clock divider: d_clk = clk / (2*half), with
// runt-free start/stop and ratio changes. Optional DEG_CLK_TOGGLE_CNT_EN adds toggle_cnt.
module deg_clk_ctrl #(
   parameter int CNT_W    = 27,
   parameter int DEF_HALF = 500000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             stop,
   input  logic             cfg_valid,
   input  logic [CNT_W-1:0] cfg_half,
   output logic             cfg_ready,
   output logic             d_clk,
   output logic             tick,
   output logic             running
`ifdef DEG_CLK_TOGGLE_CNT_EN
   ,
   output logic [15:0]      toggle_cnt
`endif
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_PEND  = 2'd2,
      S_DRAIN = 2'd3
   } state_e;

   localparam logic [CNT_W-1:0] HALF_RST = CNT_W'(DEF_HALF);
   localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] half_q, half_d;
   logic [CNT_W-1:0] shadow_q, shadow_d;
   logic             pend_q, pend_d;
   logic             d_clk_q, d_clk_d;
   logic             tick_q, tick_d;
   logic             cfg_ready_q, cfg_ready_d;
   logic             running_q, running_d;

   logic             xfer;
   logic             boundary;
   logic [CNT_W-1:0] cfg_clamped;

   assign xfer        = cfg_valid & cfg_ready_q;
   assign boundary    = (cnt_q == (half_q - ONE));
   // A zero half-period would never reach a boundary; treat it as the fastest ratio.
   assign cfg_clamped = (cfg_half == '0) ? ONE : cfg_half;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      half_d   = half_q;
      shadow_d = shadow_q;
      pend_d   = pend_q;
      d_clk_d  = d_clk_q;
      tick_d   = 1'b0;

      case (state_q)
         S_IDLE: begin
            d_clk_d = 1'b0;
            cnt_d   = '0;
            if (xfer) half_d = cfg_clamped;
            if (start && !stop) state_d = S_RUN;
         end

         S_RUN, S_PEND: begin
            if (boundary) begin
               d_clk_d = ~d_clk_q;
               tick_d  = 1'b1;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + ONE;
            end

            if (state_q == S_RUN) begin
               if (xfer) begin
                  shadow_d = cfg_clamped;
                  pend_d   = 1'b1;
                  state_d  = S_PEND;
               end
               if (stop) state_d = S_DRAIN;
            end else if (stop) begin
               // Pending ratio is kept and applied when the drain completes.
               state_d = S_DRAIN;
            end else if (boundary) begin
               half_d  = shadow_q;
               pend_d  = 1'b0;
               state_d = S_RUN;
            end
         end

         S_DRAIN: begin
            if (!d_clk_q || boundary) begin
               if (d_clk_q) begin
                  d_clk_d = 1'b0;
                  tick_d  = 1'b1;
               end
               cnt_d   = '0;
               state_d = S_IDLE;
               if (pend_q) begin
                  half_d = shadow_q;
                  pend_d = 1'b0;
               end
            end else begin
               cnt_d = cnt_q + ONE;
            end
         end

         default: state_d = S_IDLE;
      endcase

      cfg_ready_d = (state_d == S_IDLE) || (state_d == S_RUN);
      running_d   = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         half_q      <= HALF_RST;
         shadow_q    <= HALF_RST;
         pend_q      <= 1'b0;
         d_clk_q     <= 1'b0;
         tick_q      <= 1'b0;
         cfg_ready_q <= 1'b1;
         running_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         half_q      <= half_d;
         shadow_q    <= shadow_d;
         pend_q      <= pend_d;
         d_clk_q     <= d_clk_d;
         tick_q      <= tick_d;
         cfg_ready_q <= cfg_ready_d;
         running_q   <= running_d;
      end
   end

   assign cfg_ready = cfg_ready_q;
   assign d_clk     = d_clk_q;
   assign tick      = tick_q;
   assign running   = running_q;

`ifdef DEG_CLK_TOGGLE_CNT_EN
   logic [15:0] toggle_cnt_q, toggle_cnt_d;

   always_comb begin
      toggle_cnt_d = toggle_cnt_q;
      if (tick_d) toggle_cnt_d = toggle_cnt_q + 16'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) toggle_cnt_q <= '0;
      else        toggle_cnt_q <= toggle_cnt_d;
   end

   assign toggle_cnt = toggle_cnt_q;
`endif

endmodule
